// File: rtl/data_bus_arbiter_if.sv
// Request-side signal bundle between the two bus masters (CPU, DMA) and the
// shared data bus arbiter.
interface data_bus_arbiter_if;
    // Handshake: a master requests by holding mode at 01 (read) or 10 (write)
    // together with addr/wdata. The CPU's request is accepted in the cycle
    // cpu_stall is low; the DMA's in the cycle dma_done pulses. Until then the
    // master keeps mode and wdata unchanged. Modes 00 and 11 mean no request.
    logic [1:0]  cpu_mode;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic [1:0]  dma_mode;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] dma_rdata;
    logic        dma_grant;
    logic        dma_done;

    modport master (
        output cpu_mode, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_mode, dma_addr, dma_wdata,
        input  dma_rdata, dma_grant, dma_done
    );

    modport slave (
        input  cpu_mode, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_mode, dma_addr, dma_wdata,
        output dma_rdata, dma_grant, dma_done
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter for two masters sharing a 32-bit tri-state data bus.
// Writes finish in one cycle; reads take READ_WAIT setup phases plus a sample.
module data_bus_arbiter #(
    parameter int READ_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    data_bus_arbiter_if.slave req,
    output logic [31:0]       data_bus_addr,
    output logic [1:0]        data_bus_mode,
    inout  wire  [31:0]       data_bus_data,
    output logic              debug_state
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [3:0] SAMPLE_PHASE = 4'(READ_WAIT);

    state_t      state, state_next;
    logic        owner, owner_next;
    logic        last_owner, last_owner_next;
    logic [3:0]  phase, phase_next;
    logic [31:0] addr_q, addr_q_next;

    logic        cpu_req, dma_req;
    logic        win_dma;
    logic [1:0]  win_mode;
    logic [31:0] win_addr, win_wdata;

    logic        active;
    logic        cur_owner;
    logic        complete;
    logic        sample;
    logic        drive;
    logic [31:0] wdata_out;
    logic [1:0]  bus_mode;
    logic [31:0] bus_addr;

    assign cpu_req = (req.cpu_mode == MODE_READ) || (req.cpu_mode == MODE_WRITE);
    assign dma_req = (req.dma_mode == MODE_READ) || (req.dma_mode == MODE_WRITE);

    // On a tie the master that did not own the last transaction wins.
    assign win_dma   = dma_req && (!cpu_req || !last_owner);
    assign win_mode  = win_dma ? req.dma_mode  : req.cpu_mode;
    assign win_addr  = win_dma ? req.dma_addr  : req.cpu_addr;
    assign win_wdata = win_dma ? req.dma_wdata : req.cpu_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            phase      <= 4'd0;
            addr_q     <= 32'h0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_owner <= last_owner_next;
            phase      <= phase_next;
            addr_q     <= addr_q_next;
        end
    end

    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_owner_next = last_owner;
        phase_next      = phase;
        addr_q_next     = addr_q;
        active          = 1'b0;
        cur_owner       = owner;
        complete        = 1'b0;
        sample          = 1'b0;
        drive           = 1'b0;
        wdata_out       = 32'h0;
        bus_mode        = MODE_IDLE;
        bus_addr        = 32'h0;

        case (state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    active    = 1'b1;
                    cur_owner = win_dma;
                    bus_addr  = win_addr;
                    if (win_mode == MODE_WRITE) begin
                        bus_mode        = MODE_WRITE;
                        drive           = 1'b1;
                        wdata_out       = win_wdata;
                        complete        = 1'b1;
                        last_owner_next = win_dma;
                    end else begin
                        // Phase 0 of a read: address is captured here and
                        // the master's live address is ignored afterwards.
                        bus_mode    = MODE_READ;
                        state_next  = BUSY;
                        owner_next  = win_dma;
                        phase_next  = 4'd1;
                        addr_q_next = win_addr;
                    end
                end
            end
            BUSY: begin
                active    = 1'b1;
                cur_owner = owner;
                bus_mode  = MODE_READ;
                bus_addr  = addr_q;
                if (phase == SAMPLE_PHASE) begin
                    sample          = 1'b1;
                    complete        = 1'b1;
                    state_next      = IDLE;
                    last_owner_next = owner;
                    phase_next      = 4'd0;
                end else begin
                    phase_next = 4'(phase + 4'd1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs read idle for as long as reset is held, whatever is requested.
        if (!reset) begin
            active   = 1'b0;
            complete = 1'b0;
            sample   = 1'b0;
            drive    = 1'b0;
            bus_mode = MODE_IDLE;
            bus_addr = 32'h0;
        end
    end

    assign data_bus_mode = bus_mode;
    assign data_bus_addr = bus_addr;
    assign data_bus_data = drive ? wdata_out : 32'bz;

    assign req.cpu_stall = reset && cpu_req && !(complete && !cur_owner);
    assign req.dma_grant = active && cur_owner;
    assign req.dma_done  = complete && cur_owner;
    assign req.cpu_rdata = (sample && !cur_owner) ? data_bus_data : 32'h0;
    assign req.dma_rdata = (sample && cur_owner) ? data_bus_data : 32'h0;

    assign debug_state = state;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: READ_WAIT=1 instance driven from a
// vector table, READ_WAIT=3 instance driven by hand-written sequences.
module tb_data_bus_arbiter;

    typedef struct {
        logic [1:0]  cpu_mode;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic [1:0]  dma_mode;
        logic [31:0] dma_addr;
        logic [31:0] dma_wdata;
        logic [31:0] periph;
        logic        stall;
        logic [31:0] cpu_rdata;
        logic [31:0] dma_rdata;
        logic        grant;
        logic        done;
        logic [1:0]  bus_mode;
        logic [31:0] bus_addr;
        logic [31:0] bus_data;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    data_bus_arbiter_if if_a ();
    data_bus_arbiter_if if_b ();

    wire  [31:0] bus_a;
    wire  [31:0] bus_b;
    logic [31:0] addr_a, addr_b;
    logic [1:0]  mode_a, mode_b;
    logic        dbg_a, dbg_b;
    logic [31:0] periph_a, periph_b;

    // Peripheral drives the bus in every cycle that is not a write.
    assign bus_a = (mode_a != 2'b10) ? periph_a : 32'bz;
    assign bus_b = (mode_b != 2'b10) ? periph_b : 32'bz;

    data_bus_arbiter #(.READ_WAIT(1)) dut_a (
        .clk           (clk),
        .reset         (reset),
        .req           (if_a),
        .data_bus_addr (addr_a),
        .data_bus_mode (mode_a),
        .data_bus_data (bus_a),
        .debug_state   (dbg_a)
    );

    data_bus_arbiter #(.READ_WAIT(3)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .req           (if_b),
        .data_bus_addr (addr_b),
        .data_bus_mode (mode_b),
        .data_bus_data (bus_b),
        .debug_state   (dbg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [1:0] cm, input logic [31:0] ca, input logic [31:0] cw,
        input logic [1:0] dm, input logic [31:0] da, input logic [31:0] dw,
        input logic [31:0] periph,
        input logic stall, input logic [31:0] crd, input logic [31:0] drd,
        input logic grant, input logic done,
        input logic [1:0] bmode, input logic [31:0] baddr, input logic [31:0] bdata);
        vec_t v;
        v.cpu_mode = cm;  v.cpu_addr = ca;  v.cpu_wdata = cw;
        v.dma_mode = dm;  v.dma_addr = da;  v.dma_wdata = dw;
        v.periph = periph;
        v.stall = stall;  v.cpu_rdata = crd; v.dma_rdata = drd;
        v.grant = grant;  v.done = done;
        v.bus_mode = bmode; v.bus_addr = baddr; v.bus_data = bdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input bit use_b);
        if (use_b) begin
            if_b.cpu_mode = v.cpu_mode; if_b.cpu_addr = v.cpu_addr; if_b.cpu_wdata = v.cpu_wdata;
            if_b.dma_mode = v.dma_mode; if_b.dma_addr = v.dma_addr; if_b.dma_wdata = v.dma_wdata;
            periph_b = v.periph;
        end else begin
            if_a.cpu_mode = v.cpu_mode; if_a.cpu_addr = v.cpu_addr; if_a.cpu_wdata = v.cpu_wdata;
            if_a.dma_mode = v.dma_mode; if_a.dma_addr = v.dma_addr; if_a.dma_wdata = v.dma_wdata;
            periph_a = v.periph;
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v, input bit use_b);
        chk({tag, " cpu_stall"}, 32'(use_b ? if_b.cpu_stall : if_a.cpu_stall), 32'(v.stall));
        chk({tag, " cpu_rdata"}, use_b ? if_b.cpu_rdata : if_a.cpu_rdata, v.cpu_rdata);
        chk({tag, " dma_rdata"}, use_b ? if_b.dma_rdata : if_a.dma_rdata, v.dma_rdata);
        chk({tag, " dma_grant"}, 32'(use_b ? if_b.dma_grant : if_a.dma_grant), 32'(v.grant));
        chk({tag, " dma_done"}, 32'(use_b ? if_b.dma_done : if_a.dma_done), 32'(v.done));
        chk({tag, " bus_mode"}, 32'(use_b ? mode_b : mode_a), 32'(v.bus_mode));
        chk({tag, " bus_addr"}, use_b ? addr_b : addr_a, v.bus_addr);
        chk({tag, " bus_data"}, use_b ? bus_b : bus_a, v.bus_data);
    endtask

    task automatic step(input string tag, input vec_t v, input bit use_b);
        @(posedge clk);
        #1;
        apply(v, use_b);
        @(negedge clk);
        check_vec(tag, v, use_b);
    endtask

    vec_t tbl[20];
    vec_t idle_v;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        idle_v   = mk(2'b00, 0, 0, 2'b00, 0, 0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0);
        apply(idle_v, 1'b0);
        apply(idle_v, 1'b1);

        // Table for the READ_WAIT=1 instance; last_owner starts as DMA.
        tbl[0] = mk(2'b00, 0, 0, 2'b00, 0, 0, 32'h1111_1111,
                    0, 0, 0, 0, 0, 2'b00, 0, 32'h1111_1111);
        tbl[1] = mk(2'b11, 32'h500, 32'h77, 2'b00, 0, 0, 32'h2222_2222,
                    0, 0, 0, 0, 0, 2'b00, 0, 32'h2222_2222);
        tbl[2] = mk(2'b01, 32'h100, 0, 2'b00, 0, 0, 32'hDEAD_BEEF,
                    1, 0, 0, 0, 0, 2'b01, 32'h100, 32'hDEAD_BEEF);
        tbl[3] = mk(2'b01, 32'h100, 0, 2'b00, 0, 0, 32'hDEAD_BEEF,
                    0, 32'hDEAD_BEEF, 0, 0, 0, 2'b01, 32'h100, 32'hDEAD_BEEF);
        tbl[4] = mk(2'b10, 32'h40, 32'h1234, 2'b00, 0, 0, 32'h4444_4444,
                    0, 0, 0, 0, 0, 2'b10, 32'h40, 32'h1234);
        tbl[5] = mk(2'b00, 0, 0, 2'b10, 32'h20, 32'h55AA, 32'h5555_5555,
                    0, 0, 0, 1, 1, 2'b10, 32'h20, 32'h55AA);
        tbl[6] = mk(2'b00, 0, 0, 2'b00, 0, 0, 32'h3333_3333,
                    0, 0, 0, 0, 0, 2'b00, 0, 32'h3333_3333);
        for (int r = 0; r < 3; r++) begin
            logic [31:0] p;
            int b;
            p = 32'hA000_0000 + 32'(r * 16);
            b = 7 + 4 * r;
            tbl[b]     = mk(2'b01, 32'h200, 0, 2'b01, 32'h300, 0, p,
                            1, 0, 0, 0, 0, 2'b01, 32'h200, p);
            tbl[b + 1] = mk(2'b01, 32'hBAD0, 0, 2'b01, 32'h300, 0, p + 1,
                            0, p + 1, 0, 0, 0, 2'b01, 32'h200, p + 1);
            tbl[b + 2] = mk(2'b01, 32'h200, 0, 2'b01, 32'h300, 0, p + 2,
                            1, 0, 0, 1, 0, 2'b01, 32'h300, p + 2);
            tbl[b + 3] = mk(2'b01, 32'h200, 0, 2'b01, 32'hBAD4, 0, p + 3,
                            1, 0, p + 3, 1, 1, 2'b01, 32'h300, p + 3);
        end
        tbl[19] = mk(2'b00, 0, 0, 2'b00, 0, 0, 32'h6666_6666,
                     0, 0, 0, 0, 0, 2'b00, 0, 32'h6666_6666);

        // Reset state with a CPU read pending: outputs must stay idle.
        apply(mk(2'b01, 32'h100, 0, 2'b01, 32'h300, 0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0), 1'b0);
        @(negedge clk);
        check_vec("reset_a", mk(2'b01, 32'h100, 0, 2'b01, 32'h300, 0, 32'h0,
                                0, 0, 0, 0, 0, 2'b00, 0, 32'h0), 1'b0);
        check_vec("reset_b", idle_v, 1'b1);
        apply(idle_v, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step($sformatf("vec%0d", i), tbl[i], 1'b0);
        end

        // READ_WAIT=3: reset asserted in phase 1 of a DMA read.
        step("rst_p0", mk(2'b00, 0, 0, 2'b01, 32'h80, 0, 32'h0,
                          0, 0, 0, 1, 0, 2'b01, 32'h80, 32'h0), 1'b1);
        step("rst_p1", mk(2'b00, 0, 0, 2'b01, 32'h0, 0, 32'h0,
                          0, 0, 0, 1, 0, 2'b01, 32'h80, 32'h0), 1'b1);
        #2 reset = 1'b0;
        #1 check_vec("rst_async", mk(2'b00, 0, 0, 2'b01, 0, 0, 32'h0,
                                     0, 0, 0, 0, 0, 2'b00, 0, 32'h0), 1'b1);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("rst_hold%0d", i),
                 mk(2'b01, 32'h100, 0, 2'b01, 0, 0, 32'hFEED_F00D,
                    0, 0, 0, 0, 0, 2'b00, 0, 32'hFEED_F00D), 1'b1);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply(mk(2'b01, 32'h100, 0, 2'b00, 0, 0, 32'hFEED_F00D,
                 0, 0, 0, 0, 0, 2'b00, 0, 0), 1'b1);
        @(negedge clk);
        check_vec("post_rst_p0", mk(2'b01, 32'h100, 0, 2'b00, 0, 0, 32'hFEED_F00D,
                                    1, 0, 0, 0, 0, 2'b01, 32'h100, 32'hFEED_F00D), 1'b1);
        for (int i = 1; i < 3; i++) begin
            step($sformatf("post_rst_p%0d", i),
                 mk(2'b01, 32'h100, 0, 2'b00, 0, 0, 32'hFEED_F00D,
                    1, 0, 0, 0, 0, 2'b01, 32'h100, 32'hFEED_F00D), 1'b1);
        end
        step("post_rst_smp", mk(2'b01, 32'h100, 0, 2'b00, 0, 0, 32'hFEED_F00D,
                                0, 32'hFEED_F00D, 0, 0, 0, 2'b01, 32'h100, 32'hFEED_F00D), 1'b1);
        step("post_rst_idle", mk(2'b00, 0, 0, 2'b00, 0, 0, 32'h7777_7777,
                                 0, 0, 0, 0, 0, 2'b00, 0, 32'h7777_7777), 1'b1);

        // READ_WAIT=3: CPU write arrives while a DMA read is in flight.
        step("busy_p0", mk(2'b00, 0, 0, 2'b01, 32'h90, 0, 32'h0,
                           0, 0, 0, 1, 0, 2'b01, 32'h90, 32'h0), 1'b1);
        step("busy_p1", mk(2'b10, 32'h44, 32'hCAFE, 2'b01, 32'h90, 0, 32'h1,
                           1, 0, 0, 1, 0, 2'b01, 32'h90, 32'h1), 1'b1);
        step("busy_p2", mk(2'b10, 32'h44, 32'hCAFE, 2'b00, 32'h90, 0, 32'h2,
                           1, 0, 0, 1, 0, 2'b01, 32'h90, 32'h2), 1'b1);
        step("busy_smp", mk(2'b10, 32'h44, 32'hCAFE, 2'b00, 32'h90, 0, 32'h5A5A_5A5A,
                            1, 0, 32'h5A5A_5A5A, 1, 1, 2'b01, 32'h90, 32'h5A5A_5A5A), 1'b1);
        step("busy_wr", mk(2'b10, 32'h44, 32'hCAFE, 2'b00, 0, 0, 32'h3,
                           0, 0, 0, 0, 0, 2'b10, 32'h44, 32'hCAFE), 1'b1);
        step("busy_idle", mk(2'b00, 0, 0, 2'b00, 0, 0, 32'h8888_8888,
                             0, 0, 0, 0, 0, 2'b00, 0, 32'h8888_8888), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
